crack_dispatcher: RTL

CRACK_DISPATCHER -- requirements
Module: crack_dispatcher

---
 rtl/crack_dispatcher.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/crack_dispatcher.sv
// Key-space dispatcher: hands out 2^CHUNK_BITS-key chunks to cracker cores round-robin and collects their reports.
// Optional feature: define CRACK_DISPATCHER_PERF_EN to add the 32-bit search_cycles counter output.
module crack_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int KEY_BITS   = 22,
    parameter int CHUNK_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [NUM_CORES-1:0]    req,
    output logic [NUM_CORES-1:0]    grant,
    output logic [KEY_BITS-1:0]     grant_base,
    input  logic [NUM_CORES-1:0]    rpt_valid,
    input  logic [NUM_CORES-1:0]    rpt_found,
    input  logic [NUM_CORES*24-1:0] rpt_key,
    output logic [NUM_CORES-1:0]    halt,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [23:0]             key_out,
    output logic                    proto_err
`ifdef CRACK_DISPATCHER_PERF_EN
    ,
    output logic [31:0]             search_cycles
`endif
);

    localparam int          IDX_W = KEY_BITS - CHUNK_BITS;
    localparam int          PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned NC_U  = NUM_CORES;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        DRAIN     = 3'd2,
        FOUND     = 3'd3,
        EXHAUSTED = 3'd4
    } state_t;

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return PTR_W'(sum % NC_U);
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_next_idx;
    logic [NUM_CORES-1:0]   r_outstanding;
    logic [NUM_CORES-1:0]   r_grant;
    logic [NUM_CORES-1:0]   r_halt;
    logic [KEY_BITS-1:0]    r_grant_base;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [23:0]            r_key_out;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_found;
    logic                   r_proto_err;

    logic                   w_active;
    logic                   w_start_ok;
    logic                   w_err_set;
    logic                   w_issue;
    logic [NUM_CORES-1:0]   w_cand;
    logic                   w_gnt_valid;
    logic [PTR_W-1:0]       w_gnt_idx;
    logic [NUM_CORES-1:0]   w_gnt_onehot;
    logic [NUM_CORES-1:0]   w_acc;
    logic [NUM_CORES-1:0]   w_acc_find;
    logic [NUM_CORES-1:0]   w_bad;
    logic                   w_find_any;
    logic [23:0]            w_find_key;

    assign w_active   = (r_state == RUN) || (r_state == DRAIN);
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == FOUND) || (r_state == EXHAUSTED));
    assign w_err_set  = (|w_bad) && (r_state != FOUND) && (r_state != EXHAUSTED);

    // Round-robin pick among idle requesters; the descending scan leaves the first hit after the pointer
    always_comb begin
        w_cand      = req & ~r_outstanding;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            w_gnt_valid = w_gnt_valid | w_cand[rr_index(r_rr_ptr, 32'(i))];
            w_gnt_idx   = w_cand[rr_index(r_rr_ptr, 32'(i))] ? rr_index(r_rr_ptr, 32'(i)) : w_gnt_idx;
        end
        w_gnt_onehot = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_gnt_onehot[k] = w_gnt_valid && (w_gnt_idx == PTR_W'(k));
        end
    end

    // Report classification and lowest-index find selection
    always_comb begin
        w_acc      = rpt_valid & r_outstanding & {NUM_CORES{w_active}};
        w_acc_find = w_acc & rpt_found;
        w_find_any = |w_acc_find;
        w_bad      = rpt_valid & ~r_outstanding;
        w_find_key = 24'h000000;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            w_find_key = w_acc_find[i] ? rpt_key[24*i +: 24] : w_find_key;
        end
    end

    // Next-state logic; a find beats both the wrap transition and any grant
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE, FOUND, EXHAUSTED: begin
                if (start) w_state_nxt = RUN;
                else       w_state_nxt = r_state;
            end
            RUN: begin
                if (w_find_any) begin
                    w_state_nxt = FOUND;
                end else if (w_gnt_valid) begin
                    w_issue = 1'b1;
                    if (r_next_idx == {IDX_W{1'b1}}) w_state_nxt = DRAIN;
                    else                             w_state_nxt = RUN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_find_any)                               w_state_nxt = FOUND;
                else if ((r_outstanding & ~w_acc) == '0)      w_state_nxt = EXHAUSTED;
                else                                          w_state_nxt = DRAIN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, chunk counter, outstanding map, grant and sticky status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_next_idx    <= '0;
            r_outstanding <= '0;
            r_grant       <= '0;
            r_grant_base  <= '0;
            r_rr_ptr      <= '0;
            r_key_out     <= 24'h000000;
            r_proto_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_grant      <= w_gnt_onehot;
                r_grant_base <= {r_next_idx, {CHUNK_BITS{1'b0}}};
                r_rr_ptr     <= rr_index(w_gnt_idx, 32'd1);
            end else begin
                r_grant      <= '0;
            end
            if (w_start_ok) begin
                r_next_idx    <= '0;
                r_outstanding <= '0;
            end else begin
                r_next_idx    <= w_issue ? r_next_idx + IDX_W'(1) : r_next_idx;
                r_outstanding <= (r_outstanding & ~w_acc) | (w_issue ? w_gnt_onehot : '0);
            end
            if (w_active && w_find_any) r_key_out <= w_find_key;
            if (w_start_ok)      r_proto_err <= 1'b0;
            else if (w_err_set)  r_proto_err <= 1'b1;
        end
    end

    // Status outputs registered from the next state so they line up with r_state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_found <= 1'b0;
            r_halt  <= '0;
        end else begin
            r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
            r_done  <= (w_state_nxt == FOUND) || (w_state_nxt == EXHAUSTED);
            r_found <= (w_state_nxt == FOUND);
            r_halt  <= ((w_state_nxt == FOUND) || (w_state_nxt == EXHAUSTED)) ? '1 : '0;
        end
    end

`ifdef CRACK_DISPATCHER_PERF_EN
    logic [31:0] r_search_cycles;

    // Saturating count of cycles spent searching
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_search_cycles <= 32'd0;
        end else if (w_start_ok) begin
            r_search_cycles <= 32'd0;
        end else if (w_active && (r_search_cycles != 32'hFFFF_FFFF)) begin
            r_search_cycles <= r_search_cycles + 32'd1;
        end
    end

    assign search_cycles = r_search_cycles;
`endif

    assign grant      = r_grant;
    assign grant_base = r_grant_base;
    assign halt       = r_halt;
    assign busy       = r_busy;
    assign done       = r_done;
    assign found      = r_found;
    assign key_out    = r_key_out;
    assign proto_err  = r_proto_err;

endmodule
